dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port Data_Memory (8-bit addr/data, clock-edge write, mem_read-gated read).

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_rr_arb2.sv | 13 +
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the Data_Memory two-port arbiter.
// Optional feature macro: DMEM_ARB_WPROT_EN (port-1 write protection of the upper address range).
package dmem_arbiter_pkg;

    // State encoding is fixed so that external probes see IDLE=0, ACCESS=1, RESP=2.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 8;

    // Build-time switch for the port-1 write protection window.
    function automatic logic wprot_enabled();
`ifdef DMEM_ARB_WPROT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. On a tie the port that did not win last time wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic sel
);

    assign gnt_valid = req0 | req1;
    assign sel       = (req0 && req1) ? ~last_grant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port Data_Memory.
// Port 0 = CPU load/store, port 1 = debug/DMA loader. One access in flight, 3 cycles each:
// IDLE (grant) -> ACCESS (one memory strobe) -> RESP (ack pulse) -> IDLE.
// Optional feature macro: DMEM_ARB_WPROT_EN rejects port-1 writes at addr >= PROTECT_BASE.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned                ADDR_WIDTH   = DefAddrWidth,
    parameter int unsigned                DATA_WIDTH   = DefDataWidth,
    parameter logic [ADDR_WIDTH-1:0]      PROTECT_BASE = 8'hF0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // Port 0
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    // Port 1
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    // Data_Memory side
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  busy
);

    arb_state_e              r_state;
    arb_state_e              w_state_d;
    logic                    r_last_grant;
    logic                    r_sel;
    logic                    r_we;
    logic                    r_blocked;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_p0_rdata;
    logic [DATA_WIDTH-1:0]   r_p1_rdata;

    logic                    w_gnt_valid;
    logic                    w_sel;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_blocked;
    logic                    w_grant;

    rr_arb2 u_rr_arb2 (
        .req0       (p0_req),
        .req1       (p1_req),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .sel        (w_sel)
    );

    assign w_we    = w_sel ? p1_we    : p0_we;
    assign w_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_wdata = w_sel ? p1_wdata : p0_wdata;

    // A rejected write still walks through ACCESS/RESP so the requester gets its ack (with err).
    assign w_blocked = wprot_enabled() && w_sel && w_we && (w_addr >= PROTECT_BASE);
    assign w_grant   = (r_state == StIdle) && w_gnt_valid;

    // Next-state: fixed IDLE -> ACCESS -> RESP -> IDLE sequence, IDLE holds until a request.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (w_gnt_valid) w_state_d = StAccess;
            StAccess: w_state_d = StResp;
            StResp:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Latch the granted request and remember the winner for the next tie-break.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_sel        <= 1'b0;
            r_we         <= 1'b0;
            r_blocked    <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_sel;
            r_sel        <= w_sel;
            r_we         <= w_we;
            r_blocked    <= w_blocked;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
        end
    end

    // Capture read data on the edge that closes ACCESS; held until that port's next read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else if ((r_state == StAccess) && !r_we) begin
            if (r_sel) begin
                r_p1_rdata <= mem_read_data;
            end else begin
                r_p0_rdata <= mem_read_data;
            end
        end
    end

    // Strobes and acks decode straight from registered state so they drop with async reset.
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_write      = (r_state == StAccess) && r_we && !r_blocked;
    assign mem_read       = (r_state == StAccess) && !r_we;

    assign p0_ack   = (r_state == StResp) && !r_sel;
    assign p1_ack   = (r_state == StResp) && r_sel;
    assign p1_err   = (r_state == StResp) && r_sel && r_blocked;
    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;
    assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural Data_Memory.
// Honours DMEM_ARB_WPROT_EN when defined for the build.
module tb_dmem_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [7:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic       p0_ack, p1_ack, p1_err, mem_read, mem_write, busy;
    logic [7:0] p0_rdata, p1_rdata, mem_address, mem_write_data, mem_read_data;

    dmem_arbiter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .p0_req         (p0_req),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_ack         (p0_ack),
        .p0_rdata       (p0_rdata),
        .p1_req         (p1_req),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_ack         (p1_ack),
        .p1_rdata       (p1_rdata),
        .p1_err         (p1_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Behavioural Data_Memory: clock-edge write, mem_read-gated combinational read.
    logic [7:0] mem_arr [256];
    always @(posedge clock) if (mem_write) mem_arr[mem_address] <= mem_write_data;
    assign mem_read_data = mem_read ? mem_arr[mem_address] : 8'h00;

`ifdef DMEM_ARB_WPROT_EN
    localparam bit WProt = 1'b1;
`else
    localparam bit WProt = 1'b0;
`endif

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    typedef struct {
        bit         port;
        logic [7:0] rdata;
        bit         chk_rdata;
        bit         err;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit port, input bit we, input logic [7:0] rdata, input bit err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.chk_rdata = !we; e.err = err;
        sb.push_back(e);
    endtask

    task automatic ack_check();
        exp_t e;
        chk("ack_one_hot", 32'(p0_ack & p1_ack), 0);
        if (sb.size() == 0) begin
            chk("ack_expected", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("ack_port", 32'(p1_ack), 32'(e.port));
        if (e.chk_rdata) chk("rdata", 32'(e.port ? p1_rdata : p0_rdata), 32'(e.rdata));
        chk("p1_err", 32'(p1_err), 32'(e.err));
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // One isolated transaction: strobe, latency, ack and data checks.
    task automatic do_txn(input vec_t v);
        int strobes = 0;
        int lat = 0;
        bit got = 0;
        @(negedge clock);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        push_exp(v.port, v.we, v.exp_rdata, v.exp_err);
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clock); #1;
            if (mem_write || mem_read) begin
                strobes++;
                chk("mem_address", 32'(mem_address), 32'(v.addr));
                chk("mem_write", 32'(mem_write), 32'(v.we));
                chk("mem_read", 32'(mem_read), 32'(!v.we));
                if (v.we) chk("mem_write_data", 32'(mem_write_data), 32'(v.wdata));
            end
            if (p0_ack || p1_ack) begin
                got = 1;
                lat = c;
                ack_check();
                drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        if (!got) begin
            drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
            sb.delete();
        end
        chk("ack_seen", 32'(got), 1);
        chk("ack_latency", 32'(lat), 2);
        chk("strobe_cycles", 32'(strobes), v.exp_err ? 0 : 1);
        @(posedge clock); #1;
        chk("busy_after", 32'(busy), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    vec_t vecs [15];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int ack_cnt;
        int ack_cyc0;
        int ack_cyc1;

        vecs[0]  = '{0, 1, 8'h00, 8'h08, 8'h00, 0};
        vecs[1]  = '{0, 0, 8'h00, 8'h00, 8'h08, 0};
        vecs[2]  = '{1, 1, 8'h20, 8'hA5, 8'h00, 0};
        vecs[3]  = '{1, 0, 8'h20, 8'h00, 8'hA5, 0};
        vecs[4]  = '{0, 1, 8'hF4, 8'h11, 8'h00, 0};
        vecs[5]  = '{1, 1, 8'hF4, 8'h3C, 8'h00, WProt};
        vecs[6]  = '{0, 0, 8'hF4, 8'h00, WProt ? 8'h11 : 8'h3C, 0};
        vecs[7]  = '{1, 0, 8'hF4, 8'h00, WProt ? 8'h11 : 8'h3C, 0};
        vecs[8]  = '{0, 1, 8'h10, 8'h5A, 8'h00, 0};
        vecs[9]  = '{1, 1, 8'h30, 8'hC3, 8'h00, 0};
        vecs[10] = '{0, 1, 8'h31, 8'h96, 8'h00, 0};
        vecs[11] = '{1, 1, 8'hFF, 8'h7E, 8'h00, WProt};
        vecs[12] = '{0, 0, 8'hFF, 8'h00, WProt ? 8'h00 : 8'h7E, 0};
        vecs[13] = '{1, 1, 8'hEF, 8'h01, 8'h00, 0};
        vecs[14] = '{1, 0, 8'hEF, 8'h00, 8'h01, 0};

        // Seed 0xFF through port 0 so its pre-protection value is known.
        #2;
        chk("rst_p0_ack", 32'(p0_ack), 0);
        chk("rst_p1_ack", 32'(p1_ack), 0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_p0_rdata", 32'(p0_rdata), 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        do_txn('{0, 1, 8'hFF, 8'h00, 8'h00, 0});
        for (int i = 0; i < 15; i++) do_txn(vecs[i]);

        // Simultaneous requests right after reset: port 0 wins, port 1 three cycles later.
        pulse_reset();
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b1, 1'b1, 8'h20, 8'hA5);
        push_exp(0, 1'b0, 8'h5A, 0);
        push_exp(1, 1'b1, 8'h00, 0);
        ack_cyc0 = 0; ack_cyc1 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock); #1;
            if (c == 1) chk("sim_c1_read", 32'({mem_read, mem_write, mem_address}), 32'({2'b10, 8'h10}));
            if (c == 4) chk("sim_c4_write", 32'({mem_read, mem_write, mem_address, mem_write_data}),
                            32'({2'b01, 8'h20, 8'hA5}));
            if (p0_ack || p1_ack) begin
                if (p0_ack) begin ack_cyc0 = c; drive(0, 1'b0, 1'b0, 8'h00, 8'h00); end
                if (p1_ack) begin ack_cyc1 = c; drive(1, 1'b0, 1'b0, 8'h00, 8'h00); end
                ack_check();
            end
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("sim_p0_ack_cycle", 32'(ack_cyc0), 2);
        chk("sim_p1_ack_cycle", 32'(ack_cyc1), 5);
        sb.delete();

        // Both ports held for 12 cycles: strict 0,1,0,1 alternation, 4 acks.
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 8'h30, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h31, 8'h00);
        push_exp(0, 1'b0, 8'hC3, 0);
        push_exp(1, 1'b0, 8'h96, 0);
        push_exp(0, 1'b0, 8'hC3, 0);
        push_exp(1, 1'b0, 8'h96, 0);
        ack_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            if (p0_ack || p1_ack) begin
                ack_cnt++;
                chk("rr_ack_cycle", 32'(c % 3), 2);
                ack_check();
            end
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rr_ack_count", 32'(ack_cnt), 4);
        chk("rr_busy_end", 32'(busy), 0);
        @(posedge clock); #1;
        chk("rr_no_extra", 32'({busy, p0_ack, p1_ack}), 0);
        sb.delete();

        // Async reset during ACCESS: write strobe drops at once, no ack follows.
        @(negedge clock);
        drive(0, 1'b1, 1'b1, 8'h40, 8'h77);
        @(posedge clock); #1;
        chk("mid_rst_write_before", 32'(mem_write), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({mem_read, mem_write}), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_acks", 32'({p0_ack, p1_ack}), 0);
        chk("mid_rst_p0_rdata", 32'(p0_rdata), 0);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            if (p0_ack || p1_ack) ack_cnt++;
        end
        chk("mid_rst_no_ack", 32'(ack_cnt), 0);
        do_txn('{0, 1, 8'h41, 8'h42, 8'h00, 0});
        do_txn('{0, 0, 8'h41, 8'h00, 8'h42, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
